// File: rtl/mac3_pkg.sv
// Shared types and default widths for the mac3_stream sliding-window arithmetic unit.
package mac3_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned MODE_W     = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MAC  = 2'b00,
    MODE_MSC  = 2'b01,
    MODE_ADD3 = 2'b10,
    MODE_MUL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FILL0 = 2'b00,
    FILL1 = 2'b01,
    RUN   = 2'b10
  } fill_e;

endpackage

// File: rtl/mac3_alu.sv
// Combinational f(a,b,c,mode) with overflow/underflow detection.
// MAC3_SAT_EN: clamp the result on overflow/underflow instead of wrapping.
module mac3_alu
  import mac3_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);

  localparam int unsigned FULL_W = 2 * WIDTH + 1;

  logic [FULL_W-1:0] a_x, b_x, c_x, prod, full;
  logic              under, over;

  assign a_x  = FULL_W'(a_i);
  assign b_x  = FULL_W'(b_i);
  assign c_x  = FULL_W'(c_i);
  assign prod = a_x * b_x;

  // Subtraction wraps modulo 2^FULL_W; its low WIDTH bits are still the modular result.
  always_comb begin
    full = prod;
    unique case (mode_i)
      MODE_MAC:  full = prod + c_x;
      MODE_MSC:  full = prod - c_x;
      MODE_ADD3: full = a_x + b_x + c_x;
      MODE_MUL:  full = prod;
      default:   full = prod;
    endcase
  end

  assign under = (mode_i == MODE_MSC) && (prod < c_x);
  assign over  = !under && (full[FULL_W-1:WIDTH] != '0);
  assign ovf_o = under || over;

`ifdef MAC3_SAT_EN
  always_comb begin
    result_o = full[WIDTH-1:0];
    if (under) begin
      result_o = '0;
    end else if (over) begin
      result_o = '1;
    end
  end
`else
  assign result_o = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/mac3_stream.sv
// Streaming sliding-window unit: emits f(a,b,c) for each beat completing a run of >=3
// back-to-back valid beats. Optional MAC3_SAT_EN selects saturating results in mac3_alu.
module mac3_stream
  import mac3_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  run_len
);

  localparam logic [CNT_W-1:0] RUN_MAX = '1;

  fill_e             state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic              accept, brk, load;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_ovf;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign brk      = in_ready && !in_valid;

  mac3_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .c_i      (in_data),
    .mode_i   (mode_e'(mode)),
    .result_o (alu_result),
    .ovf_o    (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      run_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      run_len_q   <= run_len_d;
    end
  end

  // Window fill / run FSM plus output register and run counter.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    run_len_d   = run_len_q;
    load        = 1'b0;

    if (accept) begin
      unique case (state_q)
        FILL0: begin
          a_d     = in_data;
          state_d = FILL1;
        end
        FILL1: begin
          b_d     = in_data;
          state_d = RUN;
        end
        RUN: begin
          load = 1'b1;
          a_d  = b_q;
          b_d  = in_data;
        end
        default: state_d = FILL0;
      endcase
    end else if (brk) begin
      state_d   = FILL0;
      run_len_d = '0;
    end

    // A load with out_ready=1 overwrites the drained result without a bubble.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_result;
      out_ovf_d   = alu_ovf;
      if (run_len_q != RUN_MAX) begin
        run_len_d = run_len_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign run_len   = run_len_q;

endmodule

// File: tb/tb_mac3_stream.sv
// Directed bench for mac3_stream: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the listed scenarios.
module tb_mac3_stream;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] run_len;

  int checks = 0;
  int errors = 0;

  mac3_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .run_len   (run_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact signed value in a wide integer, then wrap/clamp.
  function automatic logic [W:0] model_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [1:0] m);
    logic [99:0] aa, bb, cc, full;
    logic        neg, ovf;
    logic [W-1:0] d;
    aa = 100'(a);
    bb = 100'(b);
    cc = 100'(c);
    case (m)
      2'd0:    full = aa * bb + cc;
      2'd1:    full = aa * bb - cc;
      2'd2:    full = aa + bb + cc;
      default: full = aa * bb;
    endcase
    neg = full[99];
    ovf = neg || (full > 100'(32'hFFFF_FFFF));
    d   = full[W-1:0];
`ifdef MAC3_SAT_EN
    if (neg) d = '0;
    else if (ovf) d = '1;
`endif
    return {ovf, d};
  endfunction

  // Model state: pending results, beats in current run, last two beats, run counter.
  logic [W:0]    exp_q[$];
  int            m_beats = 0;
  logic [W-1:0]  m_w0 = '0, m_w1 = '0;
  int            m_run = 0;
  localparam int RUN_CAP = (1 << CW) - 1;

  always @(negedge clk) begin
    logic m_rdy;
    if (rst) begin
      exp_q.delete();
      m_beats = 0;
      m_run   = 0;
    end
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || out_ready));
    chk("run_len", 64'(run_len), 64'(m_run));
    if (exp_q.size() != 0 && out_valid) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0][W-1:0]));
      chk("out_ovf", 64'(out_ovf), 64'(exp_q[0][W]));
    end
    if (!rst) begin
      m_rdy = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_rdy && in_valid) begin
        if (m_beats >= 2) begin
          exp_q.push_back(model_f(m_w0, m_w1, in_data, mode));
          if (m_run < RUN_CAP) m_run++;
        end
        m_w0 = m_w1;
        m_w1 = in_data;
        m_beats++;
      end else if (m_rdy && !in_valid) begin
        m_beats = 0;
        m_run   = 0;
      end
    end
  end

  task automatic beat(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                      input logic ordy);
    in_valid  = v;
    in_data   = d;
    mode      = m;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

`ifdef MAC3_SAT_EN
  localparam logic [W-1:0] EXP_T3 = 32'hFFFF_FFFF;
  localparam logic [W-1:0] EXP_T4 = 32'h0000_0000;
`else
  localparam logic [W-1:0] EXP_T3 = 32'h0000_0002;
  localparam logic [W-1:0] EXP_T4 = 32'hFFFF_FFFC;
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_runlen", 64'(run_len), 64'd0);
    rst = 1'b0;
    beat(0, 0, 0, 1);

    // 1: 3*4+5
    beat(1, 3, 0, 1); beat(1, 4, 0, 1); beat(1, 5, 0, 1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'd17);
    chk("t1_ovf", 64'(out_ovf), 64'd0);
    chk("t1_runlen", 64'(run_len), 64'd1);
    beat(0, 0, 0, 1);

    // 2: gap breaks the 2,3 pair
    beat(1, 2, 0, 1); beat(1, 3, 0, 1); beat(0, 0, 0, 1);
    beat(1, 4, 0, 1); beat(1, 5, 0, 1);
    chk("t2_noout", 64'(out_valid), 64'd0);
    beat(1, 6, 0, 1);
    chk("t2_data", 64'(out_data), 64'd26);
    chk("t2_runlen", 64'(run_len), 64'd1);
    beat(0, 0, 0, 1);

    // 3: overflow
    beat(1, 32'hFFFF_FFFF, 0, 1); beat(1, 32'hFFFF_FFFF, 0, 1); beat(1, 1, 0, 1);
    chk("t3_ovf", 64'(out_ovf), 64'd1);
    chk("t3_data", 64'(out_data), 64'(EXP_T3));
    beat(0, 0, 0, 1);

    // 4: underflow
    beat(1, 1, 1, 1); beat(1, 1, 1, 1); beat(1, 5, 1, 1);
    chk("t4_ovf", 64'(out_ovf), 64'd1);
    chk("t4_data", 64'(out_data), 64'(EXP_T4));
    beat(0, 0, 0, 1);

    // ADD3 then MUL within one run
    beat(1, 7, 2, 1); beat(1, 8, 2, 1); beat(1, 9, 2, 1);
    chk("add3_data", 64'(out_data), 64'd24);
    beat(1, 10, 3, 1);
    chk("mul_data", 64'(out_data), 64'd72);
    chk("mul_runlen", 64'(run_len), 64'd2);
    beat(0, 0, 0, 1);

    // 5: backpressure
    beat(1, 1, 0, 1); beat(1, 2, 0, 1); beat(1, 3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      beat(1, 4, 0, 0);
      chk("t5_stall_rdy", 64'(in_ready), 64'd0);
      chk("t5_stall_data", 64'(out_data), 64'd5);
      chk("t5_stall_run", 64'(run_len), 64'd1);
    end
    beat(1, 4, 0, 1);
    chk("t5_resume1", 64'(out_data), 64'd10);
    beat(1, 5, 0, 1);
    chk("t5_resume2", 64'(out_data), 64'd17);
    chk("t5_runlen", 64'(run_len), 64'd3);

    // 6: async reset with a result pending in RUN
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_runlen", 64'(run_len), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(1, 1, 0, 1);
    chk("t6_nobeat1", 64'(out_valid), 64'd0);
    beat(1, 2, 0, 1);
    chk("t6_nobeat2", 64'(out_valid), 64'd0);
    beat(1, 3, 0, 1);
    chk("t6_refill", 64'(out_data), 64'd5);
    beat(0, 0, 0, 1);

    // run_len saturation
    for (int i = 0; i < 20; i++) beat(1, 1, 3, 1);
    chk("sat_runlen", 64'(run_len), 64'(RUN_CAP));
    beat(0, 0, 0, 1);
    chk("brk_runlen", 64'(run_len), 64'd0);
    beat(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
